msi_directory_responder: RTL and testbench

MSI_DIRECTORY_RESPONDER -- requirements
Module: msi_directory_responder

---
 rtl/msi_directory_responder.sv | 181 ++++++++++++++++++
 tb/tb_msi_directory_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/msi_directory_responder.sv
// Two-processor MSI directory with eight lines. Each request is resolved in a
// single cycle, and its response and state update are registered on the same edge.
module msi_directory_responder (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [3:0] AddressTest,
    input  logic [1:0] WriteOrRead,
    input  logic [1:0] Processor,
    input  logic [3:0] DataTest,
    output logic       RespValid,
    output logic       RespHit,
    output logic [3:0] RespData,
    output logic [2:0] BusMsg,
    output logic [1:0] DirState,
    output logic [1:0] Sharers,
    output logic [1:0] L1State0,
    output logic [1:0] L1State1,
    output logic       ErrorFlag,
    output logic [7:0] HitCount,
    output logic [7:0] MissCount
);

    typedef enum logic [1:0] {
        L1_I = 2'b00,
        L1_S = 2'b01,
        L1_M = 2'b10
    } l1_state_e;

    typedef enum logic [1:0] {
        DIR_UNCACHED = 2'b00,
        DIR_SHARED   = 2'b01,
        DIR_MODIFIED = 2'b10
    } dir_state_e;

    typedef enum logic [2:0] {
        BUS_NONE        = 3'b000,
        BUS_READ_MISS   = 3'b001,
        BUS_WRITE_MISS  = 3'b010,
        BUS_INVALIDATE  = 3'b011,
        BUS_FETCH       = 3'b100,
        BUS_FETCH_INV   = 3'b101
    } bus_msg_e;

    typedef struct packed {
        logic [3:0]      mem_data;
        dir_state_e      dir;
        logic [1:0]      sharers;
        logic [1:0][1:0] l1;
        logic [1:0][3:0] cache;
    } line_t;

    typedef struct packed {
        logic       valid;
        logic       hit;
        logic [3:0] data;
        bus_msg_e   bus;
        dir_state_e dir;
        logic [1:0] sharers;
        logic [1:0] l1_0;
        logic [1:0] l1_1;
        logic       err;
    } resp_t;

    line_t      lines_q [8];
    line_t      lines_d [8];
    line_t      cur;
    line_t      nxt;
    resp_t      resp_q;
    resp_t      resp_d;
    logic [7:0] hit_count_q;
    logic [7:0] hit_count_d;
    logic [7:0] miss_count_q;
    logic [7:0] miss_count_d;
    logic [2:0] idx;
    logic       p;
    logic       q;

    // Codes 1..8 map onto line indices 0..7.
    assign idx = AddressTest[2:0] - 3'd1;
    assign p   = Processor[0];
    assign q   = ~Processor[0];

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        resp_d       = '0;
        lines_d      = lines_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        cur          = lines_q[idx];
        nxt          = cur;

        if (AddressTest != 4'd0) begin
            resp_d.valid = 1'b1;
            if (AddressTest > 4'd8 || WriteOrRead[1] || Processor[1]) begin
                resp_d.err = 1'b1;
            end else begin
                if (!WriteOrRead[0]) begin
                    if (cur.l1[p] != L1_I) begin
                        resp_d.hit  = 1'b1;
                        resp_d.data = cur.cache[p];
                    end else if (cur.l1[q] == L1_M) begin
                        // Owner supplies the line, writing it back and sharing it.
                        resp_d.bus   = BUS_FETCH;
                        resp_d.data  = cur.cache[q];
                        nxt.mem_data = cur.cache[q];
                        nxt.cache[p] = cur.cache[q];
                        nxt.l1[p]    = L1_S;
                        nxt.l1[q]    = L1_S;
                        nxt.dir      = DIR_SHARED;
                        nxt.sharers  = 2'b11;
                    end else begin
                        resp_d.bus      = BUS_READ_MISS;
                        resp_d.data     = cur.mem_data;
                        nxt.cache[p]    = cur.mem_data;
                        nxt.l1[p]       = L1_S;
                        nxt.dir         = DIR_SHARED;
                        nxt.sharers[p]  = 1'b1;
                    end
                end else begin
                    if (cur.l1[p] == L1_M) begin
                        resp_d.hit = 1'b1;
                    end else if (cur.l1[p] == L1_S) begin
                        resp_d.bus = BUS_INVALIDATE;
                    end else if (cur.l1[q] == L1_M) begin
                        resp_d.bus   = BUS_FETCH_INV;
                        nxt.mem_data = cur.cache[q];
                    end else begin
                        resp_d.bus = BUS_WRITE_MISS;
                    end
                    resp_d.data  = DataTest;
                    nxt.cache[p] = DataTest;
                    nxt.l1[q]    = L1_I;
                    nxt.l1[p]    = L1_M;
                    nxt.dir      = DIR_MODIFIED;
                    nxt.sharers  = p ? 2'b10 : 2'b01;
                end

                resp_d.dir     = nxt.dir;
                resp_d.sharers = nxt.sharers;
                resp_d.l1_0    = nxt.l1[0];
                resp_d.l1_1    = nxt.l1[1];
                lines_d[idx]   = nxt;

                if (resp_d.hit) begin
                    if (hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
                end else begin
                    if (miss_count_q != 8'hFF) miss_count_d = miss_count_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            resp_q       <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            // NOTE: the line store is a small flop array, so it is cleared by reset like any other state.
            for (int i = 0; i < 8; i++) lines_q[i] <= '0;
        end else begin
            resp_q       <= resp_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            for (int i = 0; i < 8; i++) lines_q[i] <= lines_d[i];
        end
    end

    assign RespValid = resp_q.valid;
    assign RespHit   = resp_q.hit;
    assign RespData  = resp_q.data;
    assign BusMsg    = resp_q.bus;
    assign DirState  = resp_q.dir;
    assign Sharers   = resp_q.sharers;
    assign L1State0  = resp_q.l1_0;
    assign L1State1  = resp_q.l1_1;
    assign ErrorFlag = resp_q.err;
    assign HitCount  = hit_count_q;
    assign MissCount = miss_count_q;

endmodule

// File: tb/tb_msi_directory_responder.sv
// Self-checking bench for msi_directory_responder: directed vector table,
// randomized traffic against an array-based protocol model, saturation and reset.
module tb_msi_directory_responder;

    logic       Clock;
    logic       Resetn;
    logic [3:0] AddressTest;
    logic [1:0] WriteOrRead;
    logic [1:0] Processor;
    logic [3:0] DataTest;
    logic       RespValid;
    logic       RespHit;
    logic [3:0] RespData;
    logic [2:0] BusMsg;
    logic [1:0] DirState;
    logic [1:0] Sharers;
    logic [1:0] L1State0;
    logic [1:0] L1State1;
    logic       ErrorFlag;
    logic [7:0] HitCount;
    logic [7:0] MissCount;

    msi_directory_responder dut (
        .Clock(Clock), .Resetn(Resetn), .AddressTest(AddressTest),
        .WriteOrRead(WriteOrRead), .Processor(Processor), .DataTest(DataTest),
        .RespValid(RespValid), .RespHit(RespHit), .RespData(RespData),
        .BusMsg(BusMsg), .DirState(DirState), .Sharers(Sharers),
        .L1State0(L1State0), .L1State1(L1State1), .ErrorFlag(ErrorFlag),
        .HitCount(HitCount), .MissCount(MissCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;

    // Protocol model: 0=I/Uncached, 1=S/Shared, 2=M/Modified.
    int m_mem   [8];
    int m_dir   [8];
    int m_l1    [8][2];
    int m_cache [8][2];
    int m_sh    [8][2];
    int m_hits;
    int m_miss;
    int e_valid, e_hit, e_data, e_bus, e_dir, e_sh, e_l0, e_l1, e_err;

    typedef struct {
        int a, w, p, d;
        int valid, hit, data, bus, dir, sh, l0, l1, err, hits, miss;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_expect();
        e_valid = 0; e_hit = 0; e_data = 0; e_bus = 0; e_dir = 0;
        e_sh = 0; e_l0 = 0; e_l1 = 0; e_err = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_mem[i] = 0; m_dir[i] = 0;
            for (int j = 0; j < 2; j++) begin
                m_l1[i][j] = 0; m_cache[i][j] = 0; m_sh[i][j] = 0;
            end
        end
        m_hits = 0; m_miss = 0;
        clear_expect();
    endtask

    task automatic model_step(input int a, input int w, input int p, input int d);
        int i, q;
        clear_expect();
        if (a == 0) return;
        e_valid = 1;
        if (a > 8 || w > 1 || p > 1) begin
            e_err = 1;
            return;
        end
        i = a - 1;
        q = 1 - p;
        if (w == 0) begin
            if (m_l1[i][p] != 0) begin
                e_hit = 1; e_data = m_cache[i][p];
            end else if (m_l1[i][q] == 2) begin
                e_bus = 4;
                m_mem[i] = m_cache[i][q];
                m_cache[i][p] = m_cache[i][q];
                m_l1[i][p] = 1; m_l1[i][q] = 1;
                m_dir[i] = 1; m_sh[i][0] = 1; m_sh[i][1] = 1;
                e_data = m_cache[i][q];
            end else begin
                e_bus = 1;
                m_cache[i][p] = m_mem[i];
                m_l1[i][p] = 1; m_dir[i] = 1; m_sh[i][p] = 1;
                e_data = m_mem[i];
            end
        end else begin
            if (m_l1[i][p] == 2)      e_bus = 0;
            else if (m_l1[i][p] == 1) e_bus = 3;
            else if (m_l1[i][q] == 2) e_bus = 5;
            else                      e_bus = 2;
            e_hit = (m_l1[i][p] == 2) ? 1 : 0;
            if (e_bus == 5) m_mem[i] = m_cache[i][q];
            m_l1[i][q] = 0; m_l1[i][p] = 2;
            m_cache[i][p] = d;
            m_dir[i] = 2; m_sh[i][p] = 1; m_sh[i][q] = 0;
            e_data = d;
        end
        if (e_hit == 1) m_hits = (m_hits < 255) ? m_hits + 1 : 255;
        else            m_miss = (m_miss < 255) ? m_miss + 1 : 255;
        e_dir = m_dir[i];
        e_sh  = m_sh[i][0] + 2 * m_sh[i][1];
        e_l0  = m_l1[i][0];
        e_l1  = m_l1[i][1];
    endtask

    task automatic drive(input int a, input int w, input int p, input int d);
        AddressTest = 4'(a); WriteOrRead = 2'(w); Processor = 2'(p); DataTest = 4'(d);
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, ".valid"}, 32'(RespValid), e_valid);
        check({tag, ".hit"},   32'(RespHit),   e_hit);
        check({tag, ".data"},  32'(RespData),  e_data);
        check({tag, ".bus"},   32'(BusMsg),    e_bus);
        check({tag, ".dir"},   32'(DirState),  e_dir);
        check({tag, ".sh"},    32'(Sharers),   e_sh);
        check({tag, ".l1_0"},  32'(L1State0),  e_l0);
        check({tag, ".l1_1"},  32'(L1State1),  e_l1);
        check({tag, ".err"},   32'(ErrorFlag), e_err);
        check({tag, ".hits"},  32'(HitCount),  m_hits);
        check({tag, ".miss"},  32'(MissCount), m_miss);
        if (RespValid && !ErrorFlag && DirState == 2'd2)
            check({tag, ".one_owner"}, 32'((L1State0 == 2'd2) + (L1State1 == 2'd2)), 1);
    endtask

    task automatic step_model(input int a, input int w, input int p, input int d, input string tag);
        drive(a, w, p, d);
        model_step(a, w, p, d);
        @(posedge Clock);
        #1;
        compare_outputs(tag);
    endtask

    initial begin
        //            a  w  p  d   val hit dat bus dir sh  l0 l1 err hits miss
        vecs[0]  = '{1, 0, 0, 0,  1,  0,  0,  1,  1,  1,  1, 0, 0,  0,  1};
        vecs[1]  = '{6, 0, 0, 0,  1,  0,  0,  1,  1,  1,  1, 0, 0,  0,  2};
        vecs[2]  = '{6, 1, 0, 7,  1,  0,  7,  3,  2,  1,  2, 0, 0,  0,  3};
        vecs[3]  = '{6, 0, 0, 0,  1,  1,  7,  0,  2,  1,  2, 0, 0,  1,  3};
        vecs[4]  = '{5, 0, 0, 0,  1,  0,  0,  1,  1,  1,  1, 0, 0,  1,  4};
        vecs[5]  = '{5, 0, 1, 0,  1,  0,  0,  1,  1,  3,  1, 1, 0,  1,  5};
        vecs[6]  = '{5, 1, 1, 8,  1,  0,  8,  3,  2,  2,  0, 2, 0,  1,  6};
        vecs[7]  = '{5, 1, 0, 9,  1,  0,  9,  5,  2,  1,  2, 0, 0,  1,  7};
        vecs[8]  = '{5, 0, 1, 0,  1,  0,  9,  4,  1,  3,  1, 1, 0,  1,  8};
        vecs[9]  = '{5, 0, 1, 0,  1,  1,  9,  0,  1,  3,  1, 1, 0,  2,  8};
        vecs[10] = '{0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0, 0, 0,  2,  8};
        vecs[11] = '{5, 2, 0, 3,  1,  0,  0,  0,  0,  0,  0, 0, 1,  2,  8};
        vecs[12] = '{9, 0, 0, 0,  1,  0,  0,  0,  0,  0,  0, 0, 1,  2,  8};
        vecs[13] = '{5, 0, 0, 0,  1,  1,  9,  0,  1,  3,  1, 1, 0,  3,  8};
        vecs[14] = '{3, 0, 3, 0,  1,  0,  0,  0,  0,  0,  0, 0, 1,  3,  8};
        vecs[15] = '{6, 0, 1, 0,  1,  0,  7,  4,  1,  3,  1, 1, 0,  3,  9};

        Resetn = 1'b0;
        drive(0, 0, 0, 0);
        model_reset();
        #12;
        compare_outputs("reset");
        @(posedge Clock);
        #1;
        Resetn = 1'b1;

        for (int k = 0; k < 16; k++) begin
            drive(vecs[k].a, vecs[k].w, vecs[k].p, vecs[k].d);
            model_step(vecs[k].a, vecs[k].w, vecs[k].p, vecs[k].d);
            @(posedge Clock);
            #1;
            check($sformatf("vec%0d.valid", k), 32'(RespValid), vecs[k].valid);
            check($sformatf("vec%0d.hit", k),   32'(RespHit),   vecs[k].hit);
            check($sformatf("vec%0d.data", k),  32'(RespData),  vecs[k].data);
            check($sformatf("vec%0d.bus", k),   32'(BusMsg),    vecs[k].bus);
            check($sformatf("vec%0d.dir", k),   32'(DirState),  vecs[k].dir);
            check($sformatf("vec%0d.sh", k),    32'(Sharers),   vecs[k].sh);
            check($sformatf("vec%0d.l1_0", k),  32'(L1State0),  vecs[k].l0);
            check($sformatf("vec%0d.l1_1", k),  32'(L1State1),  vecs[k].l1);
            check($sformatf("vec%0d.err", k),   32'(ErrorFlag), vecs[k].err);
            check($sformatf("vec%0d.hits", k),  32'(HitCount),  vecs[k].hits);
            check($sformatf("vec%0d.miss", k),  32'(MissCount), vecs[k].miss);
        end

        for (int i = 0; i < 400; i++) begin
            int a, w, p, r;
            a = $urandom_range(0, 10);
            r = $urandom_range(0, 9);
            w = (r < 4) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
            r = $urandom_range(0, 9);
            p = (r < 4) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
            step_model(a, w, p, $urandom_range(0, 15), $sformatf("rnd%0d", i));
        end

        for (int i = 0; i < 300; i++)
            step_model(1, 0, 0, 0, $sformatf("hitsat%0d", i));
        check("hit_saturated", 32'(HitCount), 255);

        for (int i = 0; i < 300; i++)
            step_model(2, 1, i % 2, i % 16, $sformatf("misssat%0d", i));
        check("miss_saturated", 32'(MissCount), 255);

        // A write is presented, then reset lands between edges and spans one.
        drive(1, 1, 0, 5);
        #2;
        Resetn = 1'b0;
        model_reset();
        #1;
        compare_outputs("async_reset");
        @(posedge Clock);
        #1;
        compare_outputs("held_reset");
        Resetn = 1'b1;
        step_model(1, 0, 0, 0, "post_reset_read");
        check("post_reset_miss", 32'(MissCount), 1);
        step_model(5, 0, 1, 0, "post_reset_line5");
        check("post_reset_line5_sh", 32'(Sharers), 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
